// File: rtl/multi_chip_readout_seq_if.sv
// Control, trigger and readout signals of the multi-chip readout sequencer.
// The master side is the register map / front-end, the slave side is the sequencer.
interface multi_chip_readout_seq_if #(
    parameter int unsigned NUM_CHIPS              = 4,
    parameter int unsigned TRIGGER_COUNTER_LENGTH = 16,
    parameter int unsigned CNT_W                  = 12,
    parameter int unsigned CH_W                   = 2
);
    logic [NUM_CHIPS-1:0]                        trig_from_chip;
    logic                                        start;
    logic                                        auto_mode;
    logic [NUM_CHIPS-1:0]                        chan_mask;
    logic [CNT_W-1:0]                            num_data;
    logic                                        abort;
    logic                                        trig_counter_clr;
    logic [NUM_CHIPS-1:0]                        read_clk_en;
    logic                                        adc_read_en;
    logic [CH_W-1:0]                             active_chan;
    logic [CNT_W-1:0]                            sample_idx;
    logic                                        busy;
    logic                                        done;
    logic [NUM_CHIPS-1:0]                        pending;
    logic [NUM_CHIPS*TRIGGER_COUNTER_LENGTH-1:0] trigger_counter;

    modport master (
        output trig_from_chip, start, auto_mode, chan_mask, num_data, abort, trig_counter_clr,
        input  read_clk_en, adc_read_en, active_chan, sample_idx, busy, done, pending,
               trigger_counter
    );

    modport slave (
        input  trig_from_chip, start, auto_mode, chan_mask, num_data, abort, trig_counter_clr,
        output read_clk_en, adc_read_en, active_chan, sample_idx, busy, done, pending,
               trigger_counter
    );
endinterface

// File: rtl/multi_chip_readout_seq.sv
// Multi-chip read/trigger sequencer: counts per-chip triggers and reads enabled chips
// one after another, lowest index first, gating one read clock per chip.
module multi_chip_readout_seq #(
    parameter int unsigned NUM_CHIPS              = 4,
    parameter int unsigned TRIGGER_COUNTER_LENGTH = 16,
    parameter int unsigned MAX_NUM_DATA           = 1280,
    parameter int unsigned READ_DELAY             = 3
) (
    input logic                     clk,
    input logic                     rstn,
    multi_chip_readout_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_NUM_DATA) + 1;
    localparam int unsigned CH_W  = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

    typedef enum logic [1:0] {StIdle, StSelect, StRead, StEndRead} state_e;

    state_e                     state_q, state_d;
    logic [NUM_CHIPS-1:0]       sync1_q, sync2_q, trig_prev_q, rise;
    logic [NUM_CHIPS-1:0][TRIGGER_COUNTER_LENGTH-1:0] cnt_q;
    logic [NUM_CHIPS-1:0]       pending_q, pending_d, scan_q, scan_d;
    logic [NUM_CHIPS-1:0]       rce_q, rce_d;
    logic                       start_q, start_rise;
    logic [CNT_W-1:0]           n_q, n_d, idx_q, idx_d, n_clamp;
    logic [CH_W-1:0]            ch_q, ch_d, lowest;
    logic [4:0]                 dly_q, dly_d;
    logic                       adc_q, adc_d, done_q, done_d, retrig_q, retrig_d;

    assign rise       = sync2_q & ~trig_prev_q;
    assign start_rise = bus.start & ~start_q;
    assign n_clamp    = (bus.num_data > CNT_W'(MAX_NUM_DATA)) ? CNT_W'(MAX_NUM_DATA)
                                                              : bus.num_data;

    always_comb begin
        lowest = '0;
        for (int i = int'(NUM_CHIPS) - 1; i >= 0; i--) begin
            if (scan_q[i]) lowest = CH_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            trig_prev_q <= '0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= bus.trig_from_chip;
            sync2_q     <= sync1_q;
            trig_prev_q <= sync2_q;
            start_q     <= bus.start;
            if (bus.trig_counter_clr) begin
                cnt_q <= '0;
            end else begin
                for (int i = 0; i < int'(NUM_CHIPS); i++) begin
                    if (rise[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            pending_q <= '0;
            scan_q    <= '0;
            rce_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            ch_q      <= '0;
            dly_q     <= '0;
            adc_q     <= 1'b0;
            done_q    <= 1'b0;
            retrig_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            scan_q    <= scan_d;
            rce_q     <= rce_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            ch_q      <= ch_d;
            dly_q     <= dly_d;
            adc_q     <= adc_d;
            done_q    <= done_d;
            retrig_q  <= retrig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | rise;
        scan_d    = scan_q;
        rce_d     = rce_q;
        n_d       = n_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        dly_d     = dly_q;
        adc_d     = adc_q;
        done_d    = 1'b0;
        retrig_d  = retrig_q;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (start_rise) begin
                    scan_d  = bus.chan_mask;
                    n_d     = n_clamp;
                    state_d = StSelect;
                end else if (bus.auto_mode && |(pending_q & bus.chan_mask)) begin
                    scan_d  = pending_q & bus.chan_mask;
                    n_d     = n_clamp;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if ((scan_q == '0) || (n_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    ch_d          = lowest;
                    rce_d         = '0;
                    rce_d[lowest] = 1'b1;
                    idx_d         = CNT_W'(1);
                    retrig_d      = rise[lowest];
                    state_d       = StRead;
                end
            end
            StRead: begin
                if (rise[ch_q]) retrig_d = 1'b1;
                adc_d = 1'b1;
                if (idx_q < n_q) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    rce_d   = '0;
                    dly_d   = 5'd1;
                    state_d = StEndRead;
                end
            end
            StEndRead: begin
                if (rise[ch_q]) retrig_d = 1'b1;
                if (dly_q <= 5'(READ_DELAY)) begin
                    dly_d = dly_q + 1'b1;
                end else begin
                    adc_d             = 1'b0;
                    scan_d[ch_q]      = 1'b0;
                    // A trigger that arrived while this chip was being read stays pending.
                    pending_d[ch_q]   = retrig_q | rise[ch_q];
                    idx_d             = '0;
                    state_d           = StSelect;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            pending_d = pending_q | rise;
            scan_d    = '0;
            rce_d     = '0;
            adc_d     = 1'b0;
            idx_d     = '0;
            done_d    = 1'b0;
        end
    end

    assign bus.read_clk_en     = rce_q;
    assign bus.adc_read_en     = adc_q;
    assign bus.active_chan     = ch_q;
    assign bus.sample_idx      = idx_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.done            = done_q;
    assign bus.pending         = pending_q;
    assign bus.trigger_counter = cnt_q;
endmodule

// File: tb/tb_multi_chip_readout_seq.sv
// Bench for multi_chip_readout_seq: scan waveforms predicted from per-chip timing rules,
// trigger counters and pending bits tracked in a small reference model.
module tb_multi_chip_readout_seq;
    localparam int NC = 4, TCL = 4, MAXN = 1280, RD = 3, CNT_W = 12, CH_W = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [3:0] pend_m;
    int   cnt_m [4];

    always #5 clk = ~clk;

    multi_chip_readout_seq_if #(
        .NUM_CHIPS(NC), .TRIGGER_COUNTER_LENGTH(TCL), .CNT_W(CNT_W), .CH_W(CH_W)
    ) bus ();

    multi_chip_readout_seq #(
        .NUM_CHIPS(NC), .TRIGGER_COUNTER_LENGTH(TCL), .MAX_NUM_DATA(MAXN), .READ_DELAY(RD)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        pend_m = '0;
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.trig_from_chip = '0; bus.start = 0; bus.auto_mode = 0; bus.chan_mask = '0;
        bus.num_data = '0; bus.abort = 0; bus.trig_counter_clr = 0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic pulse_trig(input int ch);
        bus.trig_from_chip[ch] = 1'b1;
        repeat (3) tick();
        bus.trig_from_chip[ch] = 1'b0;
        repeat (3) tick();
        if (cnt_m[ch] < 15) cnt_m[ch]++;
        pend_m[ch] = 1'b1;
    endtask

    task automatic start_scan();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = bus.busy;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: busy got 0 want 1 within 10 cycles", name);
        end
    endtask

    // Called with k=0 being the first busy cycle of a scan.
    task automatic check_scan(input string name, input logic [3:0] scan, input int n,
                              input int abort_k, input int trig_k, input int trig_ch,
                              input bit post, input bit rnd);
        int chips[$];
        int p, t_end, last_k, t;
        logic [3:0]  e_rce;
        logic        e_adc, e_busy, e_done;
        logic [11:0] e_idx;
        logic [1:0]  e_ch;
        logic [18:0] obs, exp_v;
        if (n > 0) for (int c = 0; c < 4; c++) if (scan[c]) chips.push_back(c);
        p      = n + RD + 2;
        t_end  = 1 + chips.size() * p;
        last_k = (abort_k >= 0) ? abort_k + 4 : t_end + (post ? 2 : 0);
        for (int k = 0; k <= last_k; k++) begin
            e_rce = '0; e_adc = 0; e_idx = '0; e_ch = '0;
            e_busy = (k < t_end);
            e_done = (k == t_end);
            foreach (chips[j]) begin
                t = 1 + j * p;
                if (k >= t && k < t + n) begin
                    e_rce = 4'(1 << chips[j]);
                    e_idx = 12'(k - t + 1);
                    e_ch  = 2'(chips[j]);
                end
                if (k >= t + n && k <= t + n + RD) e_idx = 12'(n);
                if (k >= t + 1 && k <= t + n + RD) e_adc = 1'b1;
            end
            if (abort_k >= 0 && k > abort_k) begin
                e_rce = '0; e_adc = 0; e_idx = '0; e_busy = 0; e_done = 0;
            end
            obs   = {bus.read_clk_en, bus.adc_read_en, bus.busy, bus.done, bus.sample_idx};
            exp_v = {e_rce, e_adc, e_busy, e_done, e_idx};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s k=%0d got rce=%b adc=%b busy=%b done=%b idx=%0d want rce=%b adc=%b busy=%b done=%b idx=%0d",
                         name, k, bus.read_clk_en, bus.adc_read_en, bus.busy, bus.done,
                         bus.sample_idx, e_rce, e_adc, e_busy, e_done, e_idx);
            end
            if (e_rce != '0) begin
                total++;
                if (bus.active_chan !== e_ch) begin
                    bad++;
                    $display("FAIL %s_chan k=%0d got %0d want %0d", name, k, bus.active_chan, e_ch);
                end
            end
            if (rnd && k == 2) begin
                bus.chan_mask = 4'($urandom);
                bus.num_data  = 12'($urandom_range(0, 20));
            end
            if (trig_k >= 0 && k == trig_k) begin
                bus.trig_from_chip[trig_ch] = 1'b1;
                if (cnt_m[trig_ch] < 15) cnt_m[trig_ch]++;
            end
            if (trig_k >= 0 && k == trig_k + 3) bus.trig_from_chip[trig_ch] = 1'b0;
            if (abort_k >= 0 && k == abort_k) bus.abort = 1'b1;
            if (abort_k >= 0 && k == abort_k + 1) bus.abort = 1'b0;
            if (k < last_k) tick();
        end
        foreach (chips[j]) if (abort_k < 0 || abort_k > 1 + j * p + n + RD) pend_m[chips[j]] = 0;
        if (trig_k >= 0) pend_m[trig_ch] = 1'b1;
        total++;
        if (bus.pending !== pend_m) begin
            bad++;
            $display("FAIL %s_pending got %b want %b", name, bus.pending, pend_m);
        end
    endtask

    task automatic test_reset();
        bit   saw;
        logic [15:0] tc;
        do_reset();
        total++;
        if ({bus.read_clk_en, bus.adc_read_en, bus.busy, bus.done, bus.pending, bus.sample_idx,
             bus.active_chan, bus.trigger_counter} !== '0) begin
            bad++;
            $display("FAIL reset_state got rce=%b adc=%b busy=%b done=%b pend=%b tc=%h want all 0",
                     bus.read_clk_en, bus.adc_read_en, bus.busy, bus.done, bus.pending,
                     bus.trigger_counter);
        end
        pulse_trig(3);
        tc = bus.trigger_counter;
        total++;
        if (tc[12 +: 4] !== 4'(cnt_m[3])) begin
            bad++;
            $display("FAIL reset_cnt3 got %0d want %0d", tc[12 +: 4], cnt_m[3]);
        end
        bus.chan_mask = 4'b0001; bus.num_data = 12'd8;
        start_scan();
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        total++;
        if ({bus.read_clk_en, bus.adc_read_en, bus.busy, bus.pending, bus.sample_idx,
             bus.trigger_counter} !== '0) begin
            bad++;
            $display("FAIL reset_mid_read got rce=%b adc=%b busy=%b pend=%b idx=%0d tc=%h want all 0",
                     bus.read_clk_en, bus.adc_read_en, bus.busy, bus.pending, bus.sample_idx,
                     bus.trigger_counter);
        end
        #2 rstn = 1'b1;
        model_clear();
        saw = 0;
        repeat (20) begin
            tick();
            if (bus.done || bus.busy) saw = 1;
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done got activity=%b want 0", saw);
        end
    endtask

    task automatic test_manual_scan();
        do_reset();
        bus.chan_mask = 4'b1010; bus.num_data = 12'd8;
        start_scan();
        check_scan("manual", 4'b1010, 8, -1, -1, 0, 1, 0);
    endtask

    task automatic test_random_scans();
        logic [3:0] m;
        int n;
        bus.auto_mode = 0;
        repeat (6) begin
            m = 4'($urandom_range(0, 15));
            n = $urandom_range(0, 12);
            bus.chan_mask = m; bus.num_data = 12'(n);
            start_scan();
            check_scan("random", m, n, -1, -1, 0, 1, 1);
        end
    endtask

    task automatic test_auto();
        logic [15:0] tc;
        do_reset();
        bus.chan_mask = 4'hF; bus.num_data = 12'd8;
        pulse_trig(2);
        tc = bus.trigger_counter;
        total++;
        if (tc[8 +: 4] !== 4'(cnt_m[2]) || bus.pending !== pend_m) begin
            bad++;
            $display("FAIL auto_trig got cnt=%0d pend=%b want cnt=%0d pend=%b",
                     tc[8 +: 4], bus.pending, cnt_m[2], pend_m);
        end
        bus.auto_mode = 1'b1;
        wait_busy("auto1_start");
        check_scan("auto1", 4'b0100, 8, -1, 2, 2, 0, 0);
        wait_busy("auto2_start");
        check_scan("auto2", 4'b0100, 8, -1, -1, 0, 0, 0);
        bus.auto_mode = 1'b0;
        repeat (3) tick();
        tc = bus.trigger_counter;
        total++;
        if (bus.busy !== 1'b0 || bus.pending !== 4'b0000 || tc[8 +: 4] !== 4'(cnt_m[2])) begin
            bad++;
            $display("FAIL auto_end got busy=%b pend=%b cnt=%0d want busy=0 pend=0000 cnt=%0d",
                     bus.busy, bus.pending, tc[8 +: 4], cnt_m[2]);
        end
    endtask

    task automatic test_counter_sat();
        logic [15:0] tc, want;
        do_reset();
        repeat (17) pulse_trig(0);
        want = {4'(cnt_m[3]), 4'(cnt_m[2]), 4'(cnt_m[1]), 4'(cnt_m[0])};
        total++;
        if (bus.trigger_counter !== want || want[3:0] !== 4'd15) begin
            bad++;
            $display("FAIL cnt_saturate got %h want %h", bus.trigger_counter, want);
        end
        bus.trig_from_chip[0] = 1'b1;
        tick();
        tick();
        bus.trig_counter_clr = 1'b1;
        tick();
        bus.trig_counter_clr = 1'b0;
        model_clear();
        pend_m[0] = 1'b1;
        total++;
        if (bus.trigger_counter !== 16'h0000) begin
            bad++;
            $display("FAIL cnt_clr_coincident got %h want 0000", bus.trigger_counter);
        end
        bus.trig_from_chip[0] = 1'b0;
        repeat (3) tick();
        pulse_trig(1);
        tc = bus.trigger_counter;
        total++;
        if (tc !== 16'h0010 || bus.pending !== pend_m) begin
            bad++;
            $display("FAIL cnt_after_clr got tc=%h pend=%b want tc=0010 pend=%b",
                     tc, bus.pending, pend_m);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        bus.chan_mask = 4'hF; bus.num_data = 12'd0;
        start_scan();
        check_scan("ndata0", 4'hF, 0, -1, -1, 0, 1, 0);
        bus.chan_mask = 4'h0; bus.num_data = 12'd5;
        start_scan();
        check_scan("mask0", 4'h0, 5, -1, -1, 0, 1, 0);
        bus.chan_mask = 4'b0001; bus.num_data = 12'd2000;
        start_scan();
        check_scan("clamp", 4'b0001, MAXN, -1, -1, 0, 1, 0);
    endtask

    task automatic test_abort();
        do_reset();
        pulse_trig(0);
        pulse_trig(1);
        bus.chan_mask = 4'b0011; bus.num_data = 12'd8;
        start_scan();
        check_scan("abort", 4'b0011, 8, 16, -1, 0, 0, 0);
        bus.auto_mode = 1'b1;
        wait_busy("abort_auto_start");
        check_scan("abort_auto", 4'b0010, 8, -1, -1, 0, 0, 0);
        bus.auto_mode = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_manual_scan();
        test_random_scans();
        test_auto();
        test_counter_sat();
        test_boundary();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
